sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port `sram` block. It shares the memory between the UART command path (port A) and a second requester (port B, the planned background/debug master).
- Selects one pending request and drives the SRAM enable/readWrite/address/dataIn lines for the required number of cycles.
- Returns read data with a one-cycle acknowledge to the winning port.
- Sits between the command FSM in the top level and the `SRAM` instance, replacing the FSM's direct SRAM drive.

---
 rtl/sram_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and access sequencer for a single-port SRAM
// Ports: clock/reset (sync, active-high); port A and port B request channels
// (req/rw/addr/wdata in, ack out); o_rdata returns read data with the owning
// ack; busy is high outside IDLE; mem_* drive the SRAM, mem_dataOut returns it.
module sram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              busy,
    output logic              mem_enable,
    output logic              mem_readWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut
);
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              busy_q, busy_d;
    logic              pick_b;

    // owner/last_grant encoding: 0 = port A, 1 = port B.
    // On a tie in round-robin mode B wins only when A was granted last.
    assign pick_b = (a_req && b_req) ? ((FIXED_PRIO == 0) && !last_q) : b_req;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    owner_d = pick_b;
                    last_d  = pick_b;
                    en_d    = 1'b1;
                    rw_d    = pick_b ? b_rw : a_rw;
                    addr_d  = pick_b ? b_addr : a_addr;
                    din_d   = rw_d ? (pick_b ? b_wdata : a_wdata) : din_q;
                    // cnt counts the remaining edges before the sampling edge
                    cnt_d   = rw_d ? '0 : CNT_W'(READ_LAT - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    en_d    = 1'b0;
                    rdata_d = rw_q ? rdata_q : mem_dataOut;
                    a_ack_d = !owner_q;
                    b_ack_d = owner_q;
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            busy_q  <= busy_d;
        end
    end

    assign a_ack         = a_ack_q;
    assign b_ack         = b_ack_q;
    assign o_rdata       = rdata_q;
    assign busy          = busy_q;
    assign mem_enable    = en_q;
    assign mem_readWrite = rw_q;
    assign mem_address   = addr_q;
    assign mem_dataIn    = din_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: checks a round-robin and a fixed-priority arbiter against a transaction-timing model
module tb_sram_arbiter;
    localparam int RL = 2;

    typedef struct packed {
        logic        rw;
        logic [14:0] ad;
        logic [31:0] wd;
    } op_t;

    typedef struct {
        int p;
        int c;
        int idle;
    } ack_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req[2][2];
    logic        rw[2][2];
    logic [14:0] ad[2][2];
    logic [31:0] wd[2][2];
    logic        hold[2][2];
    logic        aack[2], back[2], busy[2], men[2], mrw[2];
    logic [14:0] maddr[2];
    logic [31:0] mdi[2], mdo[2], rdata[2];
    logic [31:0] sram[2][32768];
    logic [31:0] mm[2][32768];

    op_t  opq[2][2][$];
    op_t  cur;
    ack_t ack_log[2][$];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    bit          m_act[2], m_own[2], m_last[2];
    int          m_t0[2], m_lat[2], m_nxt[2];
    int          w;
    logic        e_en[2], e_rw[2], e_aa[2], e_ba[2], e_busy[2];
    logic [14:0] e_ad[2];
    logic [31:0] e_di[2], e_rd[2];

    bit prev_en[2];
    int en_rise[2], lat_obs[2], idle_cnt[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_arbiter #(
            .ADDR_W(15), .DATA_W(32), .READ_LAT(RL), .FIXED_PRIO(g)
        ) dut (
            .clock(clk), .reset(rst),
            .a_req(req[g][0]), .a_rw(rw[g][0]), .a_addr(ad[g][0]), .a_wdata(wd[g][0]), .a_ack(aack[g]),
            .b_req(req[g][1]), .b_rw(rw[g][1]), .b_addr(ad[g][1]), .b_wdata(wd[g][1]), .b_ack(back[g]),
            .o_rdata(rdata[g]), .busy(busy[g]),
            .mem_enable(men[g]), .mem_readWrite(mrw[g]), .mem_address(maddr[g]),
            .mem_dataIn(mdi[g]), .mem_dataOut(mdo[g])
        );
        assign mdo[g] = sram[g][maddr[g]];
    end

    function automatic logic [31:0] init_word(input int a);
        return 32'hC3C30000 ^ a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (men[k] && mrw[k]) sram[k][maddr[k]] <= mdi[k];
    end

    // Model: a granted transfer of latency L started at edge t0 shows enable
    // after t0, ack after t0+L, idle after t0+L+1, next sample at t0+L+2.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k] = 0; m_nxt[k] = cyc + 1; m_last[k] = 1;
                e_en[k] = 0; e_rw[k] = 0; e_ad[k] = 0; e_di[k] = 0;
                e_aa[k] = 0; e_ba[k] = 0; e_rd[k] = 0; e_busy[k] = 0;
            end else begin
                e_aa[k] = 0; e_ba[k] = 0;
                if (m_act[k] && cyc == m_t0[k] + m_lat[k]) begin
                    e_en[k] = 0;
                    if (!e_rw[k]) e_rd[k] = mm[k][e_ad[k]];
                    if (m_own[k]) e_ba[k] = 1; else e_aa[k] = 1;
                end
                if (m_act[k] && cyc == m_t0[k] + m_lat[k] + 1) begin
                    e_busy[k] = 0; m_act[k] = 0;
                end
                if (!m_act[k] && cyc >= m_nxt[k] && (req[k][0] || req[k][1])) begin
                    if (req[k][0] && req[k][1]) w = (k == 1) ? 0 : (m_last[k] ? 0 : 1);
                    else w = req[k][1] ? 1 : 0;
                    m_own[k] = w[0]; m_last[k] = w[0]; m_act[k] = 1; m_t0[k] = cyc;
                    e_rw[k] = rw[k][w]; e_ad[k] = ad[k][w];
                    m_lat[k] = e_rw[k] ? 1 : RL;
                    if (e_rw[k]) begin
                        e_di[k] = wd[k][w];
                        mm[k][e_ad[k]] = wd[k][w];
                    end
                    e_en[k] = 1; e_busy[k] = 1;
                    m_nxt[k] = cyc + m_lat[k] + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("i%0d_mem_enable", k), men[k], e_en[k]);
                chk($sformatf("i%0d_mem_readWrite", k), mrw[k], e_rw[k]);
                chk($sformatf("i%0d_mem_address", k), maddr[k], e_ad[k]);
                chk($sformatf("i%0d_mem_dataIn", k), mdi[k], e_di[k]);
                chk($sformatf("i%0d_a_ack", k), aack[k], e_aa[k]);
                chk($sformatf("i%0d_b_ack", k), back[k], e_ba[k]);
                chk($sformatf("i%0d_o_rdata", k), rdata[k], e_rd[k]);
                chk($sformatf("i%0d_busy", k), busy[k], e_busy[k]);
                chk($sformatf("i%0d_ack_excl", k), aack[k] && back[k], 0);
                if (men[k] && !prev_en[k]) en_rise[k] = cyc;
                prev_en[k] = men[k];
                if (aack[k] || back[k]) begin
                    lat_obs[k] = cyc - en_rise[k];
                    ack_log[k].push_back('{p: int'(back[k]), c: cyc, idle: idle_cnt[k]});
                end
                if (!busy[k]) idle_cnt[k]++;
            end
        end
    end

    // Requesters: drop req in the ack cycle (unless holding), then load the next queued op.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                if (req[k][p] && (p == 1 ? back[k] : aack[k])) begin
                    if (!hold[k][p]) req[k][p] = 0;
                end else if (!req[k][p] && opq[k][p].size() > 0) begin
                    cur = opq[k][p].pop_front();
                    rw[k][p] = cur.rw; ad[k][p] = cur.ad; wd[k][p] = cur.wd;
                    req[k][p] = 1;
                end
            end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int k, input int p, input logic r, input logic [14:0] a, input logic [31:0] d);
        opq[k][p].push_back('{rw: r, ad: a, wd: d});
    endtask

    task automatic wait_acks(input int k, input int n, input string nm);
        int t = 0;
        while (ack_log[k].size() < n && t < 300) begin
            tick(1);
            t++;
        end
        chk(nm, ack_log[k].size() >= n, 1);
    endtask

    function automatic bit quiet();
        bit q = !busy[0] && !busy[1];
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
                q = q && !req[k][p] && opq[k][p].size() == 0;
        return q;
    endfunction

    task automatic wait_quiet(input string nm);
        int t = 0;
        while (!quiet() && t < 300) begin
            tick(1);
            t++;
        end
        tick(2);
        chk(nm, quiet(), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, n;
        int exp_rr[6] = '{0, 1, 0, 1, 0, 1};
        int exp_fp[6] = '{0, 0, 0, 0, 1, 1};
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                req[k][p] = 0; rw[k][p] = 0; ad[k][p] = 0; wd[k][p] = 0; hold[k][p] = 0;
            end
            for (int i = 0; i < 32768; i++) begin
                sram[k][i] = init_word(i);
                mm[k][i]   = init_word(i);
            end
        end
        tick(2);
        chk("reset_busy", busy[0], 0);
        chk("reset_enable", men[0], 0);
        chk("reset_rdata", rdata[0], 0);
        rst = 0;

        // simultaneous requests after reset: A read 1, B write 2
        push(0, 0, 0, 15'h0001, 0);
        push(0, 1, 1, 15'h0002, 32'h12345678);
        wait_acks(0, 2, "t2_done");
        wait_quiet("t2_quiet");
        chk("t2_first_A", ack_log[0][0].p, 0);
        chk("t2_second_B", ack_log[0][1].p, 1);
        chk("t2_one_idle", ack_log[0][1].idle - ack_log[0][0].idle, 1);
        chk("t2_rdata", rdata[0], init_word(1));

        // continuous contention: round-robin on inst 0, fixed priority on inst 1
        b0 = ack_log[0].size();
        b1 = ack_log[1].size();
        for (int i = 0; i < 3; i++) begin
            push(0, 0, i[0], 15'h0100 + 15'(i), 32'h1111 * i);
            push(0, 1, 1, 15'h0200 + 15'(i), 32'hB000 + i);
        end
        for (int i = 0; i < 4; i++) push(1, 0, 1, 15'h0300 + 15'(i), 32'hA100 + i);
        for (int i = 0; i < 2; i++) push(1, 1, 0, 15'h0400 + 15'(i), 0);
        wait_acks(0, b0 + 6, "t3_rr_done");
        wait_acks(1, b1 + 6, "t3_fp_done");
        wait_quiet("t3_quiet");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_rr_order%0d", i), ack_log[0][b0 + i].p, exp_rr[i]);
            chk($sformatf("t3_fp_order%0d", i), ack_log[1][b1 + i].p, exp_fp[i]);
        end

        // single write then read at 0x0010
        n = ack_log[0].size();
        push(0, 0, 1, 15'h0010, 32'hDEADBEEF);
        wait_acks(0, n + 1, "t1_write_done");
        chk("t1_write_lat", lat_obs[0], 1);
        wait_quiet("t1_wq");
        push(0, 0, 0, 15'h0010, 0);
        wait_acks(0, n + 2, "t1_read_done");
        chk("t1_read_lat", lat_obs[0], RL);
        chk("t1_rdata", rdata[0], 32'hDEADBEEF);
        wait_quiet("t1_rq");

        // reset while a read is in ACCESS with cnt=1
        push(0, 0, 0, 15'h0010, 0);
        n = 0;
        while (!men[0] && n < 50) begin
            tick(1);
            n++;
        end
        chk("t4_started", men[0], 1);
        rst = 1;
        tick(1);
        chk("t4_enable_off", men[0], 0);
        chk("t4_no_ack", aack[0], 0);
        chk("t4_rdata_clr", rdata[0], 0);
        chk("t4_busy_off", busy[0], 0);
        rst = 0;
        n = ack_log[0].size();
        wait_acks(0, n + 1, "t4_resume");
        wait_quiet("t4_quiet");
        chk("t4_one_ack", ack_log[0].size(), n + 1);
        chk("t4_rdata", rdata[0], 32'hDEADBEEF);

        // maximum address round trip
        n = ack_log[0].size();
        push(0, 0, 1, 15'h7FFF, 32'hFFFFFFFF);
        push(0, 0, 0, 15'h7FFF, 0);
        wait_acks(0, n + 2, "t5_done");
        wait_quiet("t5_quiet");
        chk("t5_rdata", rdata[0], 32'hFFFFFFFF);
        chk("t5_addr", maddr[0], 15'h7FFF);
        chk("t5_cell", sram[0][32767], 32'hFFFFFFFF);

        // held request: one transfer per IDLE sample
        n = ack_log[0].size();
        hold[0][0] = 1;
        push(0, 0, 1, 15'h0020, 32'h0BADF00D);
        wait_acks(0, n + 4, "t6_four");
        hold[0][0] = 0;
        wait_quiet("t6_quiet");
        chk("t6_count", ack_log[0].size(), n + 5);
        for (int i = 1; i < 5; i++)
            chk($sformatf("t6_period%0d", i), ack_log[0][n + i].c - ack_log[0][n + i - 1].c, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
